closest_pair_ctrl: RTL and testbench

Sequencer for the closest-pair datapath. It walks the triangular pair schedule (k = 1..N-1, j = 0..k-1) over a signed 8-bit array in data memory and issues one synchronous memory read per operand. It forms |data[k] − data[j]|, tracks the running minimum, and writes that minimum to the result address. It sits between the top-level start/done handshake and the shared single-port data RAM.

---
 rtl/closest_pair_pkg.sv | 25 ++
 rtl/closest_pair_ctrl_absdiff8.sv | 18 +
 rtl/closest_pair_ctrl.sv | 128 ++++++++++++
 tb/tb_closest_pair_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/closest_pair_pkg.sv
// Shared types and defaults for the closest-pair sequencer.
package closest_pair_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_K,
        RD_J,
        CMP,
        WR,
        DONE
    } state_t;

    localparam int unsigned DEF_N           = 20;
    localparam int unsigned DEF_BASE_ADDR   = 128;
    localparam int unsigned DEF_RESULT_ADDR = 127;
    localparam int unsigned DEF_AW          = 8;
    localparam int unsigned DW              = 8;
    localparam int unsigned CW              = 12;

    // Number of unordered pairs over n elements.
    function automatic int unsigned pair_count(input int unsigned n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/closest_pair_ctrl_absdiff8.sv
// Combinational |a - b| of two signed bytes, returned unsigned.
module absdiff8
    import closest_pair_pkg::*;
(
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic        [DW-1:0] abs_c
);

    logic signed [DW:0] diff_c;

    // Nine bits hold the full -255..255 difference, so the magnitude always fits in eight.
    always_comb begin
        diff_c = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
        abs_c  = diff_c[DW] ? DW'(-diff_c) : diff_c[DW-1:0];
    end

endmodule

// File: rtl/closest_pair_ctrl.sv
// Walks the triangular pair schedule over data memory and writes the minimum |data[k]-data[j]|.
module closest_pair_ctrl
    import closest_pair_pkg::*;
#(
    parameter int unsigned N           = DEF_N,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned RESULT_ADDR = DEF_RESULT_ADDR,
    parameter int unsigned AW          = DEF_AW
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_rd_en,
    input  logic signed [DW-1:0] mem_rdata,
    output logic                 mem_wr_en,
    output logic [DW-1:0]        mem_wdata,
    output logic [DW-1:0]        min_dist,
    output logic [CW-1:0]        pair_ct
);

    localparam int unsigned IW    = 7;
    localparam int unsigned PAIRS = pair_count(N);

    state_t                state;
    logic [IW-1:0]         k;
    logic [IW-1:0]         j;
    logic signed [DW-1:0]  val_k;
    logic [DW-1:0]         dist_c;
    logic [DW-1:0]         new_min_c;
    logic                  row_end_c;
    logic                  last_pair_c;

    absdiff8 u_absdiff (
        .a     (val_k),
        .b     (mem_rdata),
        .abs_c (dist_c)
    );

    // The final pair of the schedule is also the last entry of the last row.
    always_comb begin
        new_min_c   = (dist_c < min_dist) ? dist_c : min_dist;
        row_end_c   = (j == k - IW'(1));
        last_pair_c = (pair_ct == CW'(PAIRS - 1));
    end

    // Outputs are registered, so each branch drives the bus values of the state it enters.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state     <= IDLE;
            k         <= '0;
            j         <= '0;
            val_k     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            min_dist  <= DW'(255);
            pair_ct   <= '0;
        end else begin
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        k         <= IW'(1);
                        j         <= '0;
                        min_dist  <= DW'(255);
                        pair_ct   <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        mem_addr  <= AW'(BASE_ADDR + 1);
                        mem_rd_en <= 1'b1;
                        state     <= RD_K;
                    end
                end
                RD_K: begin
                    mem_addr  <= AW'(BASE_ADDR) + AW'(j);
                    mem_rd_en <= 1'b1;
                    state     <= RD_J;
                end
                RD_J: begin
                    // Only the RD_J right after RD_K has data[k] on the read bus; that one has j = 0.
                    if (j == '0) begin
                        val_k <= mem_rdata;
                    end
                    state <= CMP;
                end
                CMP: begin
                    min_dist <= new_min_c;
                    pair_ct  <= pair_ct + CW'(1);
                    if (last_pair_c) begin
                        mem_addr  <= AW'(RESULT_ADDR);
                        mem_wr_en <= 1'b1;
                        mem_wdata <= new_min_c;
                        state     <= WR;
                    end else if (row_end_c) begin
                        k         <= k + IW'(1);
                        j         <= '0;
                        mem_addr  <= AW'(BASE_ADDR) + AW'(k) + AW'(1);
                        mem_rd_en <= 1'b1;
                        state     <= RD_K;
                    end else begin
                        j         <= j + IW'(1);
                        mem_addr  <= AW'(BASE_ADDR) + AW'(j) + AW'(1);
                        mem_rd_en <= 1'b1;
                        state     <= RD_J;
                    end
                end
                WR: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_closest_pair_ctrl.sv
// Self-checking bench: table vectors, random data against a pair-search model, and multi-cycle corners.
module tb_closest_pair_ctrl;
    import closest_pair_pkg::*;

    localparam int NA   = 20;
    localparam int NB   = 2;
    localparam int BASE = 128;
    localparam int RES  = 127;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic init;
    logic start;
    logic start2;

    logic              busy, done, rd_en, wr_en;
    logic [7:0]        addr, wdata, min_dist;
    logic signed [7:0] rdata;
    logic [11:0]       pair_ct;

    logic              busy2, done2, rd_en2, wr_en2;
    logic [7:0]        addr2, wdata2, min_dist2;
    logic signed [7:0] rdata2;
    logic [11:0]       pair_ct2;

    logic signed [7:0] ram  [0:255];
    logic signed [7:0] ram2 [0:255];

    int checks   = 0;
    int failures = 0;

    closest_pair_ctrl #(.N(NA), .BASE_ADDR(BASE), .RESULT_ADDR(RES), .AW(8)) dut (
        .clk(clk), .init(init), .start(start), .busy(busy), .done(done),
        .mem_addr(addr), .mem_rd_en(rd_en), .mem_rdata(rdata), .mem_wr_en(wr_en),
        .mem_wdata(wdata), .min_dist(min_dist), .pair_ct(pair_ct)
    );

    closest_pair_ctrl #(.N(NB), .BASE_ADDR(BASE), .RESULT_ADDR(RES), .AW(8)) dut2 (
        .clk(clk), .init(init), .start(start2), .busy(busy2), .done(done2),
        .mem_addr(addr2), .mem_rd_en(rd_en2), .mem_rdata(rdata2), .mem_wr_en(wr_en2),
        .mem_wdata(wdata2), .min_dist(min_dist2), .pair_ct(pair_ct2)
    );

    // Synchronous single-port RAM models with one cycle read latency; writes are logged only.
    int         wr_cnt = 0, stray_cnt = 0, prot_err = 0;
    int         wr_cnt2 = 0, stray_cnt2 = 0, prot_err2 = 0;
    logic [7:0] wr_last = 8'h00, wr_last2 = 8'h00;

    always @(posedge clk) begin
        if (rd_en) rdata <= ram[addr];
        if (wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_last <= wdata;
            if (int'(addr) != RES) stray_cnt <= stray_cnt + 1;
        end
        if (rd_en && (int'(addr) < BASE || int'(addr) > BASE + NA - 1)) prot_err <= prot_err + 1;
        if (rd_en && wr_en) prot_err <= prot_err + 1;
        if (!rd_en && !wr_en && addr != 8'd0) prot_err <= prot_err + 1;
    end

    always @(posedge clk) begin
        if (rd_en2) rdata2 <= ram2[addr2];
        if (wr_en2) begin
            wr_cnt2  <= wr_cnt2 + 1;
            wr_last2 <= wdata2;
            if (int'(addr2) != RES) stray_cnt2 <= stray_cnt2 + 1;
        end
        if (rd_en2 && (int'(addr2) < BASE || int'(addr2) > BASE + NB - 1)) prot_err2 <= prot_err2 + 1;
        if (rd_en2 && wr_en2) prot_err2 <= prot_err2 + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: brute-force minimum distance over every unordered pair.
    function automatic int model_min(input int n);
        int best = 255;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++) begin
                int x = int'(ram[BASE + a]) - int'(ram[BASE + b]);
                if (x < 0) x = -x;
                if (x < best) best = x;
            end
        return best;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < NA; i++) begin
            case (mode)
                0: ram[BASE + i] = 8'(3 * i);
                1: ram[BASE + i] = (i % 2 == 0) ? -8'sd128 : 8'sd127;
                2: ram[BASE + i] = 8'(-120 + 12 * i);
                default: ram[BASE + i] = 8'($urandom_range(0, 255));
            endcase
        end
        if (mode == 1) ram[BASE + 5] = -8'sd128;
        if (mode == 2) ram[BASE + 19] = 8'(int'(ram[BASE + 18]) + 1);
    endtask

    // Pulse start, then count edges until done; optional extra start pulse at edge pulse_at.
    task automatic run_a(input int pulse_at, output int cyc);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_accept", {busy, done}, 2'b10);
        cyc = 0;
        while (!done && cyc < 1000) begin
            start = (cyc == pulse_at);
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int mode;
        int exp_min;
        int exp_pairs;
        int exp_cyc;
    } vec_t;

    vec_t vecs [3];
    int   cyc, w0, exp_r;

    initial begin
        vecs[0] = '{mode: 0, exp_min: 3, exp_pairs: 190, exp_cyc: 400};
        vecs[1] = '{mode: 1, exp_min: 0, exp_pairs: 190, exp_cyc: 400};
        vecs[2] = '{mode: 2, exp_min: 1, exp_pairs: 190, exp_cyc: 400};

        for (int i = 0; i < 256; i++) begin
            ram[i]  = 8'sh55;
            ram2[i] = 8'sh55;
        end
        init = 1'b1; start = 1'b0; start2 = 1'b0;
        #1;
        check("reset_ctrl", {done, busy, rd_en, wr_en}, 0);
        check("reset_addr", addr, 0);
        check("reset_wdata", wdata, 0);
        check("reset_min", min_dist, 255);
        check("reset_pairs", pair_ct, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) init = 1'b0;

        for (int v = 0; v < 3; v++) begin
            fill(vecs[v].mode);
            w0 = wr_cnt;
            run_a(-1, cyc);
            check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cyc);
            check($sformatf("vec%0d_result", v), wr_last, vecs[v].exp_min);
            check($sformatf("vec%0d_min", v), min_dist, vecs[v].exp_min);
            check($sformatf("vec%0d_pairs", v), pair_ct, vecs[v].exp_pairs);
            check($sformatf("vec%0d_writes", v), wr_cnt - w0, 1);
            check($sformatf("vec%0d_idle_bus", v), {busy, rd_en, wr_en, addr}, 0);
        end

        for (int r = 0; r < 4; r++) begin
            fill(3);
            exp_r = model_min(NA);
            w0 = wr_cnt;
            run_a(-1, cyc);
            check($sformatf("rand%0d_cycles", r), cyc, 400);
            check($sformatf("rand%0d_result", r), wr_last, exp_r);
            check($sformatf("rand%0d_pairs", r), pair_ct, NA * (NA - 1) / 2);
            check($sformatf("rand%0d_writes", r), wr_cnt - w0, 1);
        end

        // Start while busy is ignored; start in DONE restarts with the same result.
        fill(0);
        run_a(50, cyc);
        check("busy_start_cycles", cyc, 400);
        check("busy_start_result", wr_last, 3);
        run_a(-1, cyc);
        check("restart_cycles", cyc, 400);
        check("restart_result", wr_last, 3);

        // Abort mid-run.
        w0 = wr_cnt;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (150) @(posedge clk);
        #2 init = 1'b1;
        #1;
        check("abort_strobes", {rd_en, wr_en, busy, done}, 0);
        check("abort_addr", addr, 0);
        @(negedge clk) init = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_write", wr_cnt - w0, 0);
        check("abort_done", done, 0);
        run_a(-1, cyc);
        check("post_abort_cycles", cyc, 400);
        check("post_abort_result", wr_last, 3);

        // Two-element instance: extremes give the largest distance.
        ram2[BASE] = -8'sd128;
        ram2[BASE + 1] = 8'sd127;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("n2_cycles", cyc, 4);
        check("n2_result", wr_last2, 255);
        check("n2_pairs", pair_ct2, 1);
        check("n2_writes", wr_cnt2, 1);

        check("stray_writes", stray_cnt, 0);
        check("stray_writes2", stray_cnt2, 0);
        check("bus_protocol", prot_err, 0);
        check("bus_protocol2", prot_err2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
